// File: rtl/bit_and_checker.sv
// Self-check sequencer for a registered bitwise-AND block: sweeps every {B,A} vector and compares
// the returned C against a latency-matched expected pipe. Optional capture: BIT_AND_CHK_FIRST_ERR_EN.
module bit_and_checker #(
    parameter int A_W = 2,
    parameter int B_W = 3,
    parameter int C_W = 4,
    parameter int LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pi_start,
    output logic [A_W-1:0]       po_a,
    output logic [B_W-1:0]       po_b,
    input  logic [C_W-1:0]       pi_c,
    output logic                 po_busy,
    output logic                 po_done,
    output logic                 po_pass,
    output logic [7:0]           po_err_cnt,
`ifdef BIT_AND_CHK_FIRST_ERR_EN
    output logic [A_W+B_W:0]     po_vec_cnt,
    output logic [A_W+B_W-1:0]   po_first_vec,
    output logic [C_W-1:0]       po_first_c,
    output logic                 po_first_vld
`else
    output logic [A_W+B_W:0]     po_vec_cnt
`endif
);

    localparam int VW   = A_W + B_W;
    localparam int AB_W = (A_W > B_W) ? A_W : B_W;
    localparam int EW   = (AB_W > C_W) ? AB_W : C_W;
    localparam logic [VW-1:0] V_LAST = '1;
    localparam logic [3:0] DRAIN_LAST = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [VW-1:0]   v;
    logic [3:0]      drain_cnt;
    logic            live;
    logic [EW-1:0]   ea;
    logic [EW-1:0]   eb;
    logic [C_W-1:0]  exp_in;
    logic [C_W-1:0]  exp_pipe [LAT];
    logic [LAT-1:0]  vld_pipe;
    logic            exit_vld;
    logic            mismatch;

    // live marks that po_a/po_b currently present a sweep vector; its expected value enters
    // the pipe at the end of that cycle and exits exactly when the DUT's C for it is due.
    assign ea       = EW'(po_a);
    assign eb       = EW'(po_b);
    assign exp_in   = C_W'(ea & eb);
    assign exit_vld = vld_pipe[LAT-1];
    assign mismatch = exit_vld && (pi_c != exp_pipe[LAT-1]);
    assign po_busy  = (state == DRIVE) || (state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pi_start) state_nxt = DRIVE;
            DRIVE:   if (v == V_LAST) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po_a       <= '0;
            po_b       <= '0;
            v          <= '0;
            drain_cnt  <= '0;
            live       <= 1'b0;
            vld_pipe   <= '0;
            for (int i = 0; i < LAT; i++) exp_pipe[i] <= '0;
            po_done    <= 1'b0;
            po_pass    <= 1'b0;
            po_err_cnt <= '0;
            po_vec_cnt <= '0;
`ifdef BIT_AND_CHK_FIRST_ERR_EN
            po_first_vec <= '0;
            po_first_c   <= '0;
            po_first_vld <= 1'b0;
`endif
        end else begin
            po_done     <= (state == DONE);
            live        <= (state == DRIVE);
            vld_pipe[0] <= live;
            exp_pipe[0] <= exp_in;
            for (int i = LAT - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end

            if (exit_vld) begin
                po_vec_cnt <= po_vec_cnt + 1'b1;
                if (mismatch && (po_err_cnt != 8'hFF)) po_err_cnt <= po_err_cnt + 8'd1;
            end
`ifdef BIT_AND_CHK_FIRST_ERR_EN
            // Vectors leave the pipe in sweep order, so the compare count names the vector.
            if (mismatch && !po_first_vld) begin
                po_first_vld <= 1'b1;
                po_first_vec <= po_vec_cnt[VW-1:0];
                po_first_c   <= pi_c;
            end
`endif

            case (state)
                IDLE: begin
                    if (pi_start) begin
                        po_err_cnt <= '0;
                        po_vec_cnt <= '0;
                        po_pass    <= 1'b0;
                        v          <= '0;
`ifdef BIT_AND_CHK_FIRST_ERR_EN
                        po_first_vec <= '0;
                        po_first_c   <= '0;
                        po_first_vld <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    po_a      <= v[A_W-1:0];
                    po_b      <= v[VW-1:A_W];
                    v         <= v + 1'b1;
                    drain_cnt <= '0;
                end
                DRAIN: drain_cnt <= drain_cnt + 4'd1;
                // The last vector is compared during this cycle, so fold its result in.
                DONE: po_pass <= (po_err_cnt == 8'd0) && !mismatch;
                default: ;
            endcase
        end
    end

endmodule
